bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble), one bit per clock.
- Sits directly upstream of the 4-digit seven-segment driver. Converts the calculator's binary result into four BCD digits, BCD3 (thousands) to BCD0 (units).
- Digit outputs are registered and held stable between conversions, so the display never shows intermediate values.

Parameters:
- BIN_WIDTH, 14, width of the binary input (14 bits covers 0..16383).
- MAX_VALUE, 9999, largest displayable value; any input above it is an overflow.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request a conversion; accepted only when Busy=0.
- Binary  input  BIN_WIDTH  unsigned value to convert; sampled in the accept cycle only.
- Busy  output  1  conversion in progress.
- Done  output  1  single-cycle pulse; the digit outputs update in this same cycle.
- Overflow  output  1  registered; 1 if the last accepted value exceeded MAX_VALUE.
- BCD3, BCD2, BCD1, BCD0  output  4 each  thousands/hundreds/tens/units digits.

Behaviour:
- Reset (Clk edge with Reset=1, Clk: Reset is synchronous, active-high):
  - Busy=0, Done=0, Overflow=0, all BCD outputs=0, FSM goes to IDLE.
  - Reset mid-conversion aborts it; no Done pulse is produced.
- FSM states: IDLE, CONVERT, FINISH.
  - IDLE: if Start=1, latch Binary into the shift register, clear the 16-bit BCD scratch register, set iteration counter = BIN_WIDTH, latch OverflowPending = (Binary > MAX_VALUE). Go to CONVERT.
  - CONVERT, each cycle:
    - every scratch nibble >= 5 gets +3 (4-bit add, no carry-out possible);
    - then shift {scratch, shift register} left by 1;
    - decrement counter; after the BIN_WIDTH-th shift go to FINISH.
  - FINISH:
    - load BCD3..BCD0 from scratch, or 9,9,9,9 if OverflowPending;
    - Overflow <= OverflowPending;
    - Done=1 for this cycle only; go to IDLE.
- Scratch width: 16 bits (4 digits). Scratch bits shifted out above bit 15 are discarded; this only happens when the input exceeds 9999, and that case is already flagged as overflow.
- Latency: Start accepted at edge T -> Busy=1 from T+1 -> Done=1 in cycle T+BIN_WIDTH+1 (15 cycles for the default). Latency is fixed and independent of the value.
- Busy=1 in CONVERT and FINISH. A Start pulse while Busy=1 is ignored; it is not queued.
- Busy=0 in the cycle after FINISH, so back-to-back conversions take BIN_WIDTH+2 cycles each.
- BCD outputs and Overflow change only in the FINISH cycle (or on Reset); they are held otherwise.
- Binary may change freely after the accept cycle.
- Start and Reset in the same cycle: Reset wins and the Start is dropped.

Decomposition:
- Shared package `calc_pkg`: BIN_WIDTH default, NUM_DIGITS=4, MAX_VALUE=9999, state encoding (IDLE/CONVERT/FINISH), BCD_NINE=4'h9.
- One natural sub-module: `bcd_add3`, a combinational nibble adjust (in >= 5 ? in+3 : in), instantiated 4 times.

Test Plan:
- Reset, then Start with Binary=0 -> Done at cycle 15 after accept; BCD=0,0,0,0; Overflow=0.
- Binary=1234 -> Busy high for 15 cycles, one Done pulse; BCD3..0=1,2,3,4; outputs keep the prior value until the Done cycle.
- Binary=9999, then Binary=10000, then Binary=16383 -> first gives 9,9,9,9 with Overflow=0; the next two give 9,9,9,9 with Overflow=1.
- Start with 42, pulse Start with 777 at cycle 5, change Binary mid-conversion -> exactly one Done; result 0,0,4,2; the 777 request is ignored.
- Convert 5678, then assert Reset at cycle 8 of a new 4321 conversion -> outputs 0,0,0,0, Busy=0, no Done; a fresh Start with 4321 yields 4,3,2,1.
- Back-to-back: Start held high continuously with Binary=100 -> Done every 16 cycles; BCD=0,1,0,0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants for the calculator display path: widths, limits and
// the converter FSM state encoding.
package calc_pkg;
  localparam int BIN_WIDTH_DEF = 14;
  localparam int NUM_DIGITS    = 4;
  localparam int MAX_VALUE_DEF = 9999;

  localparam logic [3:0] BCD_NINE = 4'h9;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_FINISH  = 2'd2;
endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between the calculator core and the BCD converter.
interface bin_to_bcd_seq_if #(
  parameter int BIN_WIDTH = calc_pkg::BIN_WIDTH_DEF
);
  logic                 Start;
  logic [BIN_WIDTH-1:0] Binary;
  logic                 Busy;
  logic                 Done;
  logic                 Overflow;
  logic [3:0]           BCD3;
  logic [3:0]           BCD2;
  logic [3:0]           BCD1;
  logic [3:0]           BCD0;

  modport master (
    output Start, Binary,
    input  Busy, Done, Overflow, BCD3, BCD2, BCD1, BCD0
  );

  modport slave (
    input  Start, Binary,
    output Busy, Done, Overflow, BCD3, BCD2, BCD1, BCD0
  );
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: values 5..9 get +3 before the next shift.
module bcd_add3 (
  input  logic [3:0] nib_in,
  output logic [3:0] nib_out
);
  assign nib_out = (nib_in >= 4'd5) ? nib_in + 4'd3 : nib_in;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock; digit
// outputs are registered and only change when a conversion completes.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | waiting for Start, outputs hold last result
// ST_CONVERT | add-3 and shift, one bit per cycle
// ST_FINISH  | result visible, Done pulse, back to idle
module bin_to_bcd_seq
  import calc_pkg::*;
#(
  parameter int BIN_WIDTH = BIN_WIDTH_DEF,
  parameter int MAX_VALUE = MAX_VALUE_DEF
) (
  input logic             Clk,
  input logic             Reset,
  bin_to_bcd_seq_if.slave bus
);
  localparam int                 CW       = $clog2(BIN_WIDTH + 1);
  localparam int                 SW       = 4 * NUM_DIGITS;
  localparam logic [CW-1:0]      CNT_INIT = CW'(BIN_WIDTH);
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [31:0]        MAX_U    = 32'(MAX_VALUE);

  logic [1:0]           state;
  logic [BIN_WIDTH-1:0] shreg;
  logic [SW-1:0]        scratch;
  logic [SW-1:0]        adj;
  logic [SW-1:0]        scratch_nxt;
  logic [CW-1:0]        cnt;
  logic                 ovf_pend;
  logic [SW-1:0]        bcd_q;
  logic                 ovf_q;
  logic [31:0]          bin_ext;

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_adj
    bcd_add3 u_add3 (
      .nib_in  (scratch[4*d +: 4]),
      .nib_out (adj[4*d +: 4])
    );
  end

  // Bits leaving the top of the scratch only occur for overflowing inputs.
  assign scratch_nxt = (adj << 1) | {{(SW-1){1'b0}}, shreg[BIN_WIDTH-1]};
  assign bin_ext     = {{(32-BIN_WIDTH){1'b0}}, bus.Binary};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.Start) begin
            shreg    <= bus.Binary;
            scratch  <= '0;
            cnt      <= CNT_INIT;
            ovf_pend <= (bin_ext > MAX_U);
            state    <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          scratch <= scratch_nxt;
          shreg   <= shreg << 1;
          cnt     <= cnt - CNT_ONE;
          // Results are registered on the last shift so they appear together with Done.
          if (cnt == CNT_ONE) begin
            state <= ST_FINISH;
            bcd_q <= ovf_pend ? {NUM_DIGITS{BCD_NINE}} : scratch_nxt;
            ovf_q <= ovf_pend;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign bus.Busy     = (state != ST_IDLE);
  assign bus.Done     = (state == ST_FINISH);
  assign bus.Overflow = ovf_q;
  assign bus.BCD3     = bcd_q[15:12];
  assign bus.BCD2     = bcd_q[11:8];
  assign bus.BCD1     = bcd_q[7:4];
  assign bus.BCD0     = bcd_q[3:0];
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq with a result scoreboard fed at request time.
module tb_bin_to_bcd_seq;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  bin_to_bcd_seq_if #(.BIN_WIDTH(14)) bus ();

  bin_to_bcd_seq #(.BIN_WIDTH(14), .MAX_VALUE(9999)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int          n_pass = 0;
  int          n_total = 0;
  int          n_done = 0;
  int          cyc = 0;
  logic [16:0] sb_q[$];
  int          done_cyc[$];
  logic [16:0] prev_exp;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  function automatic logic [16:0] model(input int v);
    if (v > 9999) return {16'h9999, 1'b1};
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10), 1'b0};
  endfunction

  function automatic logic [16:0] obs();
    return {bus.BCD3, bus.BCD2, bus.BCD1, bus.BCD0, bus.Overflow};
  endfunction

  always @(negedge Clk) begin
    cyc++;
    if (bus.Done === 1'b1) begin
      n_done++;
      done_cyc.push_back(cyc);
      if (sb_q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
      else chk("result", 32'(obs()), 32'(sb_q.pop_front()));
    end
  end

  task automatic run(input int v, input int intrude);
    int          lat;
    int          busy_n;
    bit          held;
    logic [16:0] e;
    e = model(v);
    @(negedge Clk);
    chk("idle_before", 32'(bus.Busy), 32'd0);
    bus.Start  = 1'b1;
    bus.Binary = 14'(v);
    sb_q.push_back(e);
    @(negedge Clk);
    bus.Start  = 1'b0;
    bus.Binary = 14'($urandom_range(0, 16383));
    lat = 1; busy_n = 0; held = 1'b1;
    while (bus.Done !== 1'b1 && lat < 40) begin
      if (bus.Busy === 1'b1) busy_n++;
      if (obs() !== prev_exp) held = 1'b0;
      if (lat == intrude) begin
        bus.Start  = 1'b1;
        bus.Binary = 14'd777;
      end else begin
        bus.Start = 1'b0;
      end
      @(negedge Clk);
      lat++;
    end
    if (bus.Busy === 1'b1) busy_n++;
    chk("latency", 32'(lat), 32'd15);
    chk("busy_cycles", 32'(busy_n), 32'd15);
    chk("held_until_done", 32'(held), 32'd1);
    prev_exp = e;
    @(negedge Clk);
    chk("done_single", 32'(bus.Done), 32'd0);
    chk("idle_after", 32'(bus.Busy), 32'd0);
  endtask

  initial begin
    int n0;
    int guard;
    bus.Start  = 1'b0;
    bus.Binary = '0;
    repeat (3) @(negedge Clk);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_done", 32'(bus.Done), 32'd0);
    chk("rst_outputs", 32'(obs()), 32'd0);
    Reset    = 1'b0;
    prev_exp = '0;

    run(0, 0);
    run(1234, 0);
    run(9999, 0);
    run(10000, 0);
    run(16383, 0);
    n0 = n_done;
    run(42, 5);
    chk("one_done_with_intrusion", 32'(n_done - n0), 32'd1);
    run(5678, 0);

    // Abort a conversion with Reset partway through.
    @(negedge Clk);
    bus.Start  = 1'b1;
    bus.Binary = 14'd4321;
    @(negedge Clk);
    bus.Start = 1'b0;
    repeat (7) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("abort_busy", 32'(bus.Busy), 32'd0);
    chk("abort_done", 32'(bus.Done), 32'd0);
    chk("abort_outputs", 32'(obs()), 32'd0);
    n0 = n_done;
    repeat (20) @(negedge Clk);
    chk("abort_no_done", 32'(n_done - n0), 32'd0);
    prev_exp = '0;
    run(4321, 0);

    // Start coinciding with Reset is dropped.
    @(negedge Clk);
    Reset      = 1'b1;
    bus.Start  = 1'b1;
    bus.Binary = 14'd55;
    @(negedge Clk);
    Reset     = 1'b0;
    bus.Start = 1'b0;
    chk("start_reset_busy", 32'(bus.Busy), 32'd0);
    chk("start_reset_outputs", 32'(obs()), 32'd0);

    // Start held high: back-to-back conversions.
    done_cyc.delete();
    repeat (3) sb_q.push_back(model(100));
    @(negedge Clk);
    bus.Start  = 1'b1;
    bus.Binary = 14'd100;
    guard = 0;
    while (done_cyc.size() < 3 && guard < 100) begin
      @(negedge Clk);
      guard++;
    end
    bus.Start = 1'b0;
    chk("b2b_count", 32'(done_cyc.size()), 32'd3);
    if (done_cyc.size() >= 3) begin
      chk("b2b_period1", 32'(done_cyc[1] - done_cyc[0]), 32'd16);
      chk("b2b_period2", 32'(done_cyc[2] - done_cyc[1]), 32'd16);
    end
    n0 = n_done;
    repeat (20) @(negedge Clk);
    chk("b2b_no_extra", 32'(n_done - n0), 32'd0);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
